// File: rtl/lsu_bus_bridge.sv
// Load/store bridge: one valid/ready data-memory transaction per CPU request, with
// misalignment rejection. Define LSU_TIMEOUT_EN to add the response timeout counter.
module lsu_bus_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr_cpu,
  input  logic [31:0] data_cpu_o,
  input  logic [3:0]  strb_cpu,
  input  logic [1:0]  size_cpu,
  input  logic        wvalid_cpu,
  input  logic        rvalid_cpu,
  output logic [31:0] data_cpu_i,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_we,
  output logic        m_valid,
  input  logic        m_ready,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  input  logic        m_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t      r_state, w_next;
  logic        r_err, r_is_load;
  logic        w_req, w_conflict, w_misalign, w_reject, w_timeout;
  logic        w_strb_ok;
  logic [1:0]  w_low_idx;

  if (TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  assign w_req      = wvalid_cpu | rvalid_cpu;
  assign w_conflict = wvalid_cpu & rvalid_cpu;
  assign w_reject   = w_conflict | w_misalign;

  // Only contiguous, naturally sized strobe patterns are legal; the lowest lane must match the address.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_strb_ok = 1'b0;
    w_low_idx = 2'd0;
    case (strb_cpu)
      4'b0001, 4'b0011, 4'b1111: begin w_strb_ok = 1'b1; w_low_idx = 2'd0; end
      4'b0010:                   begin w_strb_ok = 1'b1; w_low_idx = 2'd1; end
      4'b0100, 4'b1100:          begin w_strb_ok = 1'b1; w_low_idx = 2'd2; end
      4'b1000:                   begin w_strb_ok = 1'b1; w_low_idx = 2'd3; end
      default:                   begin w_strb_ok = 1'b0; w_low_idx = 2'd0; end
    endcase
  end

  always_comb begin
    w_misalign = 1'b0;
    if (rvalid_cpu) begin
      case (size_cpu)
        2'b01:   w_misalign = addr_cpu[0];
        2'b10:   w_misalign = (addr_cpu[1:0] != 2'b00);
        2'b11:   w_misalign = 1'b1;
        default: w_misalign = 1'b0;
      endcase
    end else begin
      w_misalign = !w_strb_ok || (w_low_idx != addr_cpu[1:0]);
    end
  end

`ifdef LSU_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] r_cnt;

  // Held at zero outside REQ/RESP, so it is already clear on entry to REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      r_cnt <= '0;
    else if (r_state == S_REQ || r_state == S_RESP)  r_cnt <= r_cnt + 1'b1;
    else                                             r_cnt <= '0;
  end

  assign w_timeout = (r_state == S_REQ || r_state == S_RESP) &&
                     (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_req) w_next = w_reject ? S_DONE : S_REQ;
      S_REQ:   if (w_timeout) w_next = S_DONE;
               else if (m_ready) w_next = S_RESP;
      S_RESP:  if (m_rvalid || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
      m_we       <= 1'b0;
      m_valid    <= 1'b0;
      data_cpu_i <= '0;
      r_err      <= 1'b0;
      r_is_load  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_err <= w_reject;
            if (!w_reject) begin
              m_addr    <= {addr_cpu[31:2], 2'b00};
              m_wdata   <= data_cpu_o;
              m_wstrb   <= wvalid_cpu ? strb_cpu : 4'b0000;
              m_we      <= wvalid_cpu;
              m_valid   <= 1'b1;
              r_is_load <= rvalid_cpu;
            end
          end
        end
        S_REQ: begin
          if (w_timeout) begin
            m_valid <= 1'b0;
            r_err   <= 1'b1;
          end else if (m_ready) begin
            m_valid <= 1'b0;
          end
        end
        S_RESP: begin
          // A response in the final counted cycle still wins over the timeout.
          if (m_rvalid) begin
            r_err <= m_err;
            if (r_is_load && !m_err) data_cpu_i <= m_rdata;
          end else if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu_busy = (r_state != S_IDLE);
  assign lsu_done = (r_state == S_DONE);
  assign lsu_err  = (r_state == S_DONE) && r_err;

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// Directed bench for lsu_bus_bridge: stimulus tasks push expected completions into a
// scoreboard queue that an independent monitor drains on every lsu_done pulse.
module tb_lsu_bus_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr_cpu, data_cpu_o, data_cpu_i;
  logic [3:0]  strb_cpu;
  logic [1:0]  size_cpu;
  logic        wvalid_cpu, rvalid_cpu;
  logic        lsu_busy, lsu_done, lsu_err;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_we, m_valid, m_ready, m_rvalid, m_err;

  lsu_bus_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .addr_cpu(addr_cpu), .data_cpu_o(data_cpu_o), .strb_cpu(strb_cpu), .size_cpu(size_cpu),
    .wvalid_cpu(wvalid_cpu), .rvalid_cpu(rvalid_cpu),
    .data_cpu_i(data_cpu_i), .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_err(lsu_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_we(m_we), .m_valid(m_valid),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Completion monitor: each done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && lsu_done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("done_err", {31'd0, lsu_err}, {31'd0, e.err});
        check("done_data", data_cpu_i, e.data);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_req;
    wvalid_cpu = 1'b0;
    rvalid_cpu = 1'b0;
  endtask

  // Full bus transaction: slave stalls rdly cycles, optionally pulses m_rvalid in the handshake cycle.
  task automatic bus_txn(input string tag, input logic is_wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb, input logic [1:0] size,
                         input int rdly, input logic early_rv, input logic [31:0] rdata,
                         input logic berr, input logic [31:0] exp_maddr, input logic [3:0] exp_wstrb);
    exp_t e;
    e.err  = berr;
    e.data = (!is_wr && !berr) ? rdata : last_data;
    last_data = e.data;
    sb_q.push_back(e);
    addr_cpu = addr; data_cpu_o = wdata; strb_cpu = strb; size_cpu = size;
    wvalid_cpu = is_wr; rvalid_cpu = !is_wr;
    tick;
    check({tag, "_maddr"}, m_addr, exp_maddr);
    check({tag, "_wstrb"}, {28'd0, m_wstrb}, {28'd0, exp_wstrb});
    check({tag, "_we"}, {31'd0, m_we}, {31'd0, is_wr});
    if (is_wr) check({tag, "_wdata"}, m_wdata, wdata);
    for (int i = 0; i < rdly; i++) begin
      check({tag, "_valid_stall"}, {31'd0, m_valid}, 32'd1);
      tick;
      check({tag, "_maddr_stable"}, m_addr, exp_maddr);
    end
    m_ready = 1'b1;
    if (early_rv) begin
      m_rvalid = 1'b1;
      m_rdata  = 32'hBAD0_BAD0;
    end
    check({tag, "_valid_hs"}, {31'd0, m_valid}, 32'd1);
    tick;
    m_ready = 1'b0;
    check({tag, "_valid_resp"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_busy_resp"}, {31'd0, lsu_busy}, 32'd1);
    m_rvalid = 1'b1; m_rdata = rdata; m_err = berr;
    tick;
    m_rvalid = 1'b0; m_err = 1'b0;
    check({tag, "_done"}, {31'd0, lsu_done}, 32'd1);
    clr_req;
    tick;
    check({tag, "_done_clr"}, {31'd0, lsu_done}, 32'd0);
    check({tag, "_idle"}, {31'd0, lsu_busy}, 32'd0);
  endtask

  // Rejected request: error pulse next cycle, no bus activity.
  task automatic err_txn(input string tag, input logic wv, input logic rv, input logic [31:0] addr,
                         input logic [3:0] strb, input logic [1:0] size);
    exp_t e;
    e.err = 1'b1;
    e.data = last_data;
    sb_q.push_back(e);
    addr_cpu = addr; data_cpu_o = 32'h5A5A_5A5A; strb_cpu = strb; size_cpu = size;
    wvalid_cpu = wv; rvalid_cpu = rv;
    tick;
    check({tag, "_done"}, {31'd0, lsu_done}, 32'd1);
    check({tag, "_novalid"}, {31'd0, m_valid}, 32'd0);
    clr_req;
    tick;
    check({tag, "_novalid2"}, {31'd0, m_valid}, 32'd0);
    check({tag, "_idle"}, {31'd0, lsu_busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    addr_cpu = '0; data_cpu_o = '0; strb_cpu = '0; size_cpu = '0;
    wvalid_cpu = 1'b0; rvalid_cpu = 1'b0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_err = 1'b0;
    #2;
    check("rst_valid", {31'd0, m_valid}, 32'd0);
    check("rst_busy", {31'd0, lsu_busy}, 32'd0);
    check("rst_done", {31'd0, lsu_done}, 32'd0);
    check("rst_data", data_cpu_i, 32'd0);
    check("rst_maddr", m_addr, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    bus_txn("ld_word", 1'b0, 32'h0000_1004, 32'h0, 4'b0000, 2'b10, 0, 1'b0,
            32'hDEAD_BEEF, 1'b0, 32'h0000_1004, 4'b0000);
    bus_txn("st_byte", 1'b1, 32'h0000_2003, 32'hAB00_0000, 4'b1000, 2'b00, 3, 1'b0,
            32'h7777_7777, 1'b0, 32'h0000_2000, 4'b1000);
    bus_txn("ld_half", 1'b0, 32'h0000_2002, 32'h0, 4'b0000, 2'b01, 1, 1'b1,
            32'hCAFE_0000, 1'b0, 32'h0000_2000, 4'b0000);
    bus_txn("ld_berr", 1'b0, 32'h0000_0010, 32'h0, 4'b0000, 2'b10, 0, 1'b0,
            32'h1234_5678, 1'b1, 32'h0000_0010, 4'b0000);
    bus_txn("ld_byte", 1'b0, 32'h0000_2001, 32'h0, 4'b0000, 2'b00, 0, 1'b0,
            32'h0000_5500, 1'b0, 32'h0000_2000, 4'b0000);
    bus_txn("st_word", 1'b1, 32'h0000_4000, 32'h1122_3344, 4'b1111, 2'b10, 0, 1'b0,
            32'h0, 1'b0, 32'h0000_4000, 4'b1111);

    err_txn("mis_st_half", 1'b1, 1'b0, 32'h0000_3001, 4'b0011, 2'b00);
    err_txn("mis_ld_word", 1'b0, 1'b1, 32'h0000_3002, 4'b0000, 2'b10);
    err_txn("mis_ld_sz3",  1'b0, 1'b1, 32'h0000_3000, 4'b0000, 2'b11);
    err_txn("mis_st_0101", 1'b1, 1'b0, 32'h0000_3000, 4'b0101, 2'b00);
    err_txn("mis_st_lane", 1'b1, 1'b0, 32'h0000_3001, 4'b1100, 2'b00);
    err_txn("both_req",    1'b1, 1'b1, 32'h0000_3000, 4'b1111, 2'b10);

`ifdef LSU_TIMEOUT_EN
    begin : timeout_test
      exp_t e;
      int   edges;
      e.err = 1'b1; e.data = last_data;
      sb_q.push_back(e);
      addr_cpu = 32'h0000_0040; size_cpu = 2'b10; rvalid_cpu = 1'b1;
      m_ready = 1'b1;
      tick;
      edges = 1;
      tick;
      edges++;
      m_ready = 1'b0;
      while (!lsu_done && edges < 40) begin
        tick;
        edges++;
      end
      check("tmo_edges", edges, 32'd17);
      check("tmo_valid", {31'd0, m_valid}, 32'd0);
      clr_req;
      tick;
    end
`endif

    // Reset asserted while waiting in RESP: outputs clear at once, no done pulse.
    addr_cpu = 32'h0000_0050; size_cpu = 2'b10; rvalid_cpu = 1'b1;
    tick;
    m_ready = 1'b1;
    tick;
    m_ready = 1'b0;
    check("rst_mid_busy_pre", {31'd0, lsu_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, lsu_busy}, 32'd0);
    check("rst_mid_done", {31'd0, lsu_done}, 32'd0);
    check("rst_mid_valid", {31'd0, m_valid}, 32'd0);
    check("rst_mid_data", data_cpu_i, 32'd0);
    check("rst_mid_maddr", m_addr, 32'd0);
    clr_req;
    last_data = 32'h0;
    tick; tick;
    rst_n = 1'b1;
    tick; tick;
    check("rst_mid_idle", {31'd0, lsu_busy}, 32'd0);

    bus_txn("ld_after_rst", 1'b0, 32'h0000_0808, 32'h0, 4'b0000, 2'b10, 0, 1'b0,
            32'h0BAD_F00D, 1'b0, 32'h0000_0808, 4'b0000);

    for (int i = 0; i < 10 && sb_q.size() != 0; i++) tick;
    check("sb_drain", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
Multi-cycle load/store unit sitting directly downstream of the core control unit. It takes the formatted store data and byte strobes, the byte address (ALU result) and a load/store request. It runs one transaction on a simple valid/ready data-memory bus and returns the raw 32-bit read word to the control unit's load-extension logic. It also provides a done/error pulse, so the FSM can hold its memory state until the access completes. It rejects misaligned accesses without issuing a bus transaction.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed from bus request to response before a timeout error (only with LSU_TIMEOUT_EN); minimum 2.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
addr_cpu  in  32  byte address (ALU output)
data_cpu_o  in  32  lane-aligned store data from control unit
strb_cpu  in  4  store byte strobes
size_cpu  in  2  access size for loads: 00 byte, 01 half, 10 word (funct3[1:0])
wvalid_cpu  in  1  store request, held until lsu_done
rvalid_cpu  in  1  load request, held until lsu_done
data_cpu_i  out  32  raw read word to load extension
lsu_busy  out  1  transaction in progress
lsu_done  out  1  one-cycle completion pulse
lsu_err  out  1  valid with lsu_done: misaligned, bus error or timeout
m_addr  out  32  word-aligned bus address {addr_cpu[31:2],2'b00}
m_wdata  out  32  bus write data
m_wstrb  out  4  bus byte strobes (0000 for loads)
m_we  out  1  1 = write
m_valid  out  1  request valid
m_ready  in  1  slave accepts request
m_rvalid  in  1  response/ack valid (reads and writes)
m_rdata  in  32  read data
m_err  in  1  slave error, sampled with m_rvalid

Behaviour:
- Clock and reset: clk is the single clock; rst_n is asynchronous, active-low. Reset mid-transaction aborts immediately, with no done pulse.
- Reset values: state IDLE; all outputs 0, including data_cpu_i and all m_* outputs.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - Samples requests.
  - wvalid_cpu and rvalid_cpu both 1: go to DONE with err.
  - Misaligned access: go to DONE with err.
  - Otherwise: latch addr, wdata, strb and we into the m_* registers, set m_valid=1, go to REQ.
- Misalignment rules:
  - Load size 01 with addr[0]=1 is misaligned.
  - Load size 10 with addr[1:0]!=0 is misaligned.
  - Load size 11 is misaligned.
  - A store whose strb is not one of 0001, 0010, 0100, 1000, 0011, 1100, 1111 is misaligned.
  - A store whose lowest set strb bit index differs from addr[1:0] is misaligned.
- REQ: m_valid held with stable m_* signals until m_ready=1; on the handshake edge, clear m_valid and go to RESP.
- RESP:
  - Wait for m_rvalid.
  - On m_rvalid: if a load, register m_rdata into data_cpu_i; record err=m_err; go to DONE.
  - m_rvalid in the same cycle as the handshake is ignored; a response is earliest the cycle after.
- DONE: lsu_done=1 and lsu_err=recorded flag for exactly one cycle, then go to IDLE. Requests are ignored in DONE.
- lsu_busy: 1 in REQ and RESP, and in DONE.
- data_cpu_i: holds its last load value until the next successful load. It is not updated on stores, errors or bus-error loads.
- Minimum latency: request seen at edge N, m_valid from N+1. With m_ready=1 at N+1 and m_rvalid at N+2, lsu_done is high in cycle N+3.
- Protocol requirement: the requester drops its request in the cycle after lsu_done. A request still high in IDLE after DONE starts a new transaction.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ and RESP.
  - When it reaches TIMEOUT_CYCLES-1 without completing, clear m_valid and go to DONE with err=1.
  - data_cpu_i is unchanged on timeout.
  - A late m_rvalid arriving in IDLE is ignored.
- Undefined: no counter; REQ and RESP wait indefinitely.

Test Plan:
- Word load: rvalid_cpu=1, addr=0x0000_1004, size=10; slave m_ready=1 immediately, m_rvalid next cycle with m_rdata=0xDEADBEEF -> m_addr=0x1004, m_we=0, m_wstrb=0000; lsu_done 3 cycles after request; data_cpu_i=0xDEADBEEF; lsu_err=0.
- Byte store: wvalid_cpu=1, addr=0x2003, strb=1000, data=0xAB000000; slave ready delayed 3 cycles -> m_valid stable for 4 cycles; m_addr=0x2000, m_wstrb=1000, m_we=1; single done pulse; data_cpu_i unchanged.
- Misaligned half store: addr=0x3001, strb=0011 -> no m_valid ever; lsu_done and lsu_err=1 in the cycle after the request.
- Misaligned word load: addr=0x3002, size=10 -> no m_valid ever; lsu_done and lsu_err=1 in the cycle after the request.
- Bus error: load with m_err=1 alongside m_rvalid -> lsu_err=1 with done; data_cpu_i keeps its previous value.
- Both requests at once: wvalid_cpu=rvalid_cpu=1 -> err pulse with no bus activity.
- Timeout and reset: with LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts m_rvalid -> done and err at counter 15, m_valid low. In a separate run, assert rst_n low during RESP -> all outputs 0 immediately and no done pulse.
